// File: rtl/inst_mem_loader.sv
// inst_mem_loader: streams a host-supplied configuration image, chunk by chunk, into the FSM
// instruction-memory shift register. Optional trailing checksum word: define LOADER_CHECKSUM_EN.

module inst_mem_loader #(
  parameter int INPUT_WIDTH = 1,   // must divide HOST_WIDTH and MEM_WIDTH
  parameter int HOST_WIDTH  = 8,
  parameter int MEM_WIDTH   = 160
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   host_valid,
  input  logic [HOST_WIDTH-1:0]  host_data,
  output logic                   host_ready,
  output logic                   prog_enable,
  output logic                   prog_advance,
  output logic [INPUT_WIDTH-1:0] prog_data,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  localparam int TOTAL_CHUNKS = MEM_WIDTH / INPUT_WIDTH;
  localparam int WORD_CHUNKS  = HOST_WIDTH / INPUT_WIDTH;
  localparam int CNT_W        = $clog2(TOTAL_CHUNKS + 1);
  localparam int WCNT_W       = $clog2(WORD_CHUNKS + 1);

  localparam logic [CNT_W-1:0]  CNT_TERMINAL = CNT_W'(TOTAL_CHUNKS);
  localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(TOTAL_CHUNKS - 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST    = WCNT_W'(WORD_CHUNKS - 1);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_CHECK, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;
`endif

  state_t                state_q, state_d;
  logic [HOST_WIDTH-1:0] buffer_q;
  logic [CNT_W-1:0]      chunk_cnt_q;
  logic [WCNT_W-1:0]     word_cnt_q;

  logic accept;
  logic restart;
  logic last_chunk;
  logic word_end;

  assign last_chunk = (chunk_cnt_q == CNT_LAST);
  assign word_end   = (word_cnt_q == WCNT_LAST);
  assign accept     = host_valid & host_ready;

  // Next state and Moore outputs.
  // NOTE: every output and next-state term gets a default before the case so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    host_ready   = 1'b0;
    prog_enable  = 1'b0;
    prog_advance = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    restart      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          restart = 1'b1;
        end
      end

      S_LOAD: begin
        host_ready  = ~abort;
        prog_enable = 1'b1;
        busy        = 1'b1;
        if (host_valid && !abort) state_d = S_SHIFT;
      end

      S_SHIFT: begin
        prog_enable  = 1'b1;
        prog_advance = 1'b1;
        busy         = 1'b1;
        if (last_chunk) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CHECK;
`else
          state_d = S_DONE;
`endif
        end else if (word_end) begin
          state_d = S_LOAD;
        end
      end

`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        host_ready  = ~abort;
        prog_enable = 1'b1;
        busy        = 1'b1;
        if (host_valid && !abort) state_d = S_DONE;
      end
`endif

      S_DONE: begin
        done = 1'b1;
        if (start) begin
          state_d = S_LOAD;
          restart = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Abort beats everything, including a simultaneous start.
    if (abort) begin
      state_d = S_IDLE;
      restart = 1'b0;
    end
  end

  assign prog_data = (state_q == S_SHIFT) ? buffer_q[HOST_WIDTH-1 -: INPUT_WIDTH] : '0;

  // NOTE: sequential state is only ever written with non-blocking assignments.
  always_ff @(posedge clock) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      buffer_q    <= '0;
      chunk_cnt_q <= '0;
      word_cnt_q  <= '0;
    end else if (abort || restart) begin
      chunk_cnt_q <= '0;
      word_cnt_q  <= '0;
    end else if (state_q == S_LOAD && accept) begin
      buffer_q   <= host_data;
      word_cnt_q <= '0;
    end else if (state_q == S_SHIFT) begin
      buffer_q   <= buffer_q << INPUT_WIDTH;
      word_cnt_q <= word_cnt_q + WCNT_W'(1);
      if (chunk_cnt_q != CNT_TERMINAL) chunk_cnt_q <= chunk_cnt_q + CNT_W'(1);
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running sum covers every accepted image word, including a partially used final word.
  logic [HOST_WIDTH-1:0] sum_q;
  logic                  error_q;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      sum_q   <= '0;
      error_q <= 1'b0;
    end else if (abort || restart) begin
      sum_q   <= '0;
      error_q <= 1'b0;
    end else if (accept && state_q == S_LOAD) begin
      sum_q <= sum_q + host_data;
    end else if (accept && state_q == S_CHECK && host_data != sum_q) begin
      error_q <= 1'b1;
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader: two instances (1-bit and 2-bit chunks), a behavioural
// shift-register memory model, and randomized images with random host stalls.

module tb_inst_mem_loader;

  localparam int N = 2;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  logic       start_v [N];
  logic       abort_v [N];
  logic       valid_v [N];
  logic [7:0] data_v  [N];
  logic       ready_o [N];
  logic       en_o    [N];
  logic       adv_o   [N];
  logic       busy_o  [N];
  logic       done_o  [N];
  logic       err_o   [N];
  logic [1:0] pd_o    [N];
  logic       pd_a;
  logic [1:0] pd_b;

  assign pd_o[0] = {1'b0, pd_a};
  assign pd_o[1] = pd_b;

  inst_mem_loader #(.INPUT_WIDTH(1), .HOST_WIDTH(8), .MEM_WIDTH(20)) u_dut_a (
    .clock(clock), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]),
    .host_valid(valid_v[0]), .host_data(data_v[0]), .host_ready(ready_o[0]),
    .prog_enable(en_o[0]), .prog_advance(adv_o[0]), .prog_data(pd_a),
    .busy(busy_o[0]), .done(done_o[0]), .error(err_o[0])
  );

  inst_mem_loader #(.INPUT_WIDTH(2), .HOST_WIDTH(8), .MEM_WIDTH(16)) u_dut_b (
    .clock(clock), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]),
    .host_valid(valid_v[1]), .host_data(data_v[1]), .host_ready(ready_o[1]),
    .prog_enable(en_o[1]), .prog_advance(adv_o[1]), .prog_data(pd_b),
    .busy(busy_o[1]), .done(done_o[1]), .error(err_o[1])
  );

  function automatic int iw_of(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic int mw_of(input int i);
    return (i == 0) ? 20 : 16;
  endfunction

  function automatic logic [31:0] mask_of(input int i);
    return (32'd1 << mw_of(i)) - 32'd1;
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory model: a MEM_WIDTH shift register that takes prog_data on every prog_advance.
  int          cyc          = 0;
  logic [31:0] mem [N]      = '{32'd0, 32'd0};
  int          pulses [N]   = '{0, 0};
  int          last_adv [N] = '{0, 0};
  int          done_rise [N] = '{0, 0};
  logic        done_prev [N] = '{1'b0, 1'b0};
  int          proto_err [N] = '{0, 0};

  always @(negedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (adv_o[i]) begin
        mem[i]      <= ((mem[i] << iw_of(i)) | 32'(pd_o[i])) & mask_of(i);
        pulses[i]   <= pulses[i] + 1;
        last_adv[i] <= cyc;
      end
      if (done_o[i] && !done_prev[i]) done_rise[i] <= cyc;
      done_prev[i] <= done_o[i];
      if ((adv_o[i] && !en_o[i]) || (en_o[i] != busy_o[i]) || (done_o[i] && busy_o[i]) ||
          (!adv_o[i] && pd_o[i] != 2'd0))
        proto_err[i] <= proto_err[i] + 1;
    end
    cyc <= cyc + 1;
  end

  logic [7:0] wq [$];

  task automatic wait_ready(input int i);
    for (int n = 0; n < 64 && !ready_o[i]; n++) @(negedge clock);
    check("ready_wait", 32'(ready_o[i]), 1);
  endtask

  task automatic push(input int i, input logic [7:0] w, input int stall);
    int bad;
    bad = 0;
    valid_v[i] = 1'b0;
    if (stall > 0) begin
      wait_ready(i);
      for (int s = 0; s < stall; s++) begin
        if (!en_o[i] || adv_o[i] || !ready_o[i]) bad++;
        @(negedge clock);
      end
      check("stall_hold", 32'(bad), 0);
    end
    valid_v[i] = 1'b1;
    data_v[i]  = w;
    wait_ready(i);
    @(negedge clock);
    valid_v[i] = 1'b0;
  endtask

  task automatic pulse_start(input int i);
    start_v[i] = 1'b1;
    @(negedge clock);
    start_v[i] = 1'b0;
  endtask

  // Full load of the words in wq; expectations come from the concatenated image.
  task automatic run_load(input int i, input int smin, input int smax, input bit bad_sum,
                          input bit poke);
    int          base_p, base_e;
    logic [63:0] img;
    logic [7:0]  sum;
    logic [31:0] exp_img;
    base_p = pulses[i];
    base_e = proto_err[i];
    pulse_start(i);
    check("start_ready", 32'(ready_o[i]), 1);
    check("start_done", 32'(done_o[i]), 0);
    check("start_err", 32'(err_o[i]), 0);
    img = '0;
    sum = '0;
    foreach (wq[k]) begin
      img = (img << 8) | 64'(wq[k]);
      sum = sum + wq[k];
      push(i, wq[k], (k == 0) ? 0 : int'($urandom_range(smax, smin)));
      if (poke && k == 0) pulse_start(i);
    end
    exp_img = 32'(img >> (wq.size() * 8 - mw_of(i)));
`ifdef LOADER_CHECKSUM_EN
    push(i, sum ^ {7'd0, bad_sum}, 0);
`endif
    for (int n = 0; n < 200 && !done_o[i]; n++) @(negedge clock);
    check("done_seen", 32'(done_o[i]), 1);
    @(negedge clock);
    check("pulses", 32'(pulses[i] - base_p), 32'(mw_of(i) / iw_of(i)));
    check("image", mem[i] & mask_of(i), exp_img);
    check("done_busy", 32'(busy_o[i]), 0);
    check("done_en", 32'(en_o[i]), 0);
    check("done_err", 32'(err_o[i]), 32'(bad_sum));
`ifndef LOADER_CHECKSUM_EN
    check("done_latency", 32'(done_rise[i] - last_adv[i]), 1);
`endif
    check("protocol", 32'(proto_err[i] - base_e), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      start_v[i] = 1'b0;
      abort_v[i] = 1'b0;
      valid_v[i] = 1'b0;
      data_v[i]  = 8'h00;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clock);
    for (int i = 0; i < N; i++) begin
      check("rst_ready", 32'(ready_o[i]), 0);
      check("rst_en", 32'(en_o[i]), 0);
      check("rst_adv", 32'(adv_o[i]), 0);
      check("rst_pd", 32'(pd_o[i]), 0);
      check("rst_busy", 32'(busy_o[i]), 0);
      check("rst_done", 32'(done_o[i]), 0);
      check("rst_err", 32'(err_o[i]), 0);
    end
    rst_n = 1'b1;
    @(negedge clock);

    // Basic image, then the same image with 5-cycle host stalls between words.
    wq = '{8'hA5, 8'h3C, 8'h9F};
    run_load(0, 0, 0, 1'b0, 1'b0);
    run_load(0, 5, 5, 1'b0, 1'b0);

    // Abort inside the second word, together with a start that must lose.
    pulse_start(0);
    push(0, 8'h11, 0);
    push(0, 8'h22, 0);
    repeat (3) @(negedge clock);
    check("abort_pre_busy", 32'(busy_o[0]), 1);
    abort_v[0] = 1'b1;
    start_v[0] = 1'b1;
    @(negedge clock);
    abort_v[0] = 1'b0;
    start_v[0] = 1'b0;
    check("abort_busy", 32'(busy_o[0]), 0);
    check("abort_done", 32'(done_o[0]), 0);
    check("abort_en", 32'(en_o[0]), 0);
    check("abort_ready", 32'(ready_o[0]), 0);
    check("abort_adv", 32'(adv_o[0]), 0);
    @(negedge clock);
    check("abort_idle", 32'(ready_o[0]), 0);
    wq = '{8'hA5, 8'h3C, 8'h9F};
    run_load(0, 0, 2, 1'b0, 1'b0);

    // Two-bit chunks; start pulses arriving mid-load are ignored.
    wq = '{8'hF0, 8'h0F};
    run_load(1, 0, 0, 1'b0, 1'b0);
    run_load(1, 0, 3, 1'b0, 1'b1);
    wq = '{8'h6B, 8'hD2, 8'h47};
    run_load(0, 0, 3, 1'b0, 1'b1);

    // Reset in the middle of a load.
    pulse_start(0);
    push(0, 8'h5A, 0);
    repeat (2) @(negedge clock);
    rst_n = 1'b0;
    @(negedge clock);
    check("midrst_busy", 32'(busy_o[0]), 0);
    check("midrst_en", 32'(en_o[0]), 0);
    check("midrst_ready", 32'(ready_o[0]), 0);
    rst_n = 1'b1;
    @(negedge clock);

`ifdef LOADER_CHECKSUM_EN
    wq = '{8'h12, 8'h34};
    run_load(1, 0, 0, 1'b0, 1'b0);
    run_load(1, 0, 0, 1'b1, 1'b0);
    run_load(1, 0, 2, 1'b0, 1'b0);
`endif

    // Randomized images and stalls on both instances.
    for (int r = 0; r < 16; r++) begin
      int i;
      i = r % 2;
      wq.delete();
      for (int k = 0; k < (mw_of(i) + 7) / 8; k++) wq.push_back(8'($urandom_range(255, 0)));
      run_load(i, 0, 3, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
